// File: rtl/order_pkg.sv
// -----------------------------------------------------------------------------
// order_pkg
// Shared types for the order fill engine: order side, the queued order record
// (side plus the market price sampled on arrival) and the fill FSM states.
// -----------------------------------------------------------------------------
package order_pkg;

   // Width of the price field carried in every queued order
   localparam int ORD_PRICE_W = 16;

   typedef enum logic {
      SIDE_BUY  = 1'b0,
      SIDE_SELL = 1'b1
   } side_t;

   typedef struct packed {
      side_t                  side;
      logic [ORD_PRICE_W-1:0] price;
   } order_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      PRESENT = 2'd2
   } fill_state_t;

   // Map the sell request line onto an order side
   function automatic side_t side_of(input logic sell);
      return sell ? SIDE_SELL : SIDE_BUY;
   endfunction

endpackage

// File: rtl/order_fifo.sv
// -----------------------------------------------------------------------------
// order_fifo
// Synchronous FIFO of order records. Pointers carry one extra wrap bit so that
// full and empty are told apart when the index bits match.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   push, din    : write request and data (ignored while full)
//   pop, dout    : read request (ignored while empty) and head entry
//   full, empty  : status, both derived from the registered pointers
// -----------------------------------------------------------------------------
module order_fifo
   import order_pkg::*;
#(
   parameter int  DEPTH = 8,
   parameter type T     = order_t
) (
   input  logic clk,
   input  logic reset_n,
   input  logic push,
   input  logic pop,
   input  T     din,
   output T     dout,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr_r;
   logic [AW:0] rd_ptr_r;
   T            mem_r [DEPTH];

   assign empty = (wr_ptr_r == rd_ptr_r);
   assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign dout  = mem_r[rd_ptr_r[AW-1:0]];

   // Read/write pointer advance
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
      end else begin
         if (push && !full) begin
            wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
         end
         if (pop && !empty) begin
            rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
         end
      end
   end

   // Entry storage; contents are only meaningful between the pointers
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem_r[wr_ptr_r[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/order_fill_engine.sv
// -----------------------------------------------------------------------------
// order_fill_engine
// Exchange-side model: queues buy/sell pulses with the price seen on arrival,
// presents each as a fill LATENCY cycles after it leaves the queue, and keeps
// a saturating signed net position.
// Optional feature macro: ORDER_POS_LIMIT_EN - discard orders at pop time
// whose fill would take |position| beyond MAX_POS (order_reject pulses).
// Ports:
//   clk, reset_n             : clock, asynchronous active-low reset
//   buy_order, sell_order    : order request pulses
//   mkt_price                : price captured with each accepted order
//   fill_valid/ready         : fill handshake; fill_side/fill_price held while valid
//   position                 : signed net position (buys minus sells)
//   order_drop/conflict/reject : one-cycle event flags
//   busy                     : queue non-empty or a fill in progress
// -----------------------------------------------------------------------------
module order_fill_engine
   import order_pkg::*;
#(
   parameter int PRICE_W = ORD_PRICE_W,
   parameter int POS_W   = 12,
   parameter int DEPTH   = 8,
   parameter int LATENCY = 4,
   parameter int MAX_POS = 100
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               buy_order,
   input  logic               sell_order,
   input  logic [PRICE_W-1:0] mkt_price,
   output logic               fill_valid,
   output logic               fill_side,
   output logic [PRICE_W-1:0] fill_price,
   input  logic               fill_ready,
   output logic [POS_W-1:0]   position,
   output logic               order_drop,
   output logic               order_conflict,
   output logic               order_reject,
   output logic               busy
);

   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
   localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
`ifdef ORDER_POS_LIMIT_EN
   localparam bit LIMIT_EN = 1'b1;
`else
   localparam bit LIMIT_EN = 1'b0;
`endif

   // Step the position by one in the direction of the side, clamping at the rails
   function automatic logic signed [POS_W-1:0] pos_step(input logic signed [POS_W-1:0] pos,
                                                        input side_t side);
      logic signed [POS_W-1:0] res;
      if (side == SIDE_BUY) begin
         res = (pos == POS_MAX) ? pos : pos + POS_W'(1);
      end else begin
         res = (pos == POS_MIN) ? pos : pos - POS_W'(1);
      end
      return res;
   endfunction

   fill_state_t             state_r, state_nxt_s;
   logic [CNT_W-1:0]        cnt_r, cnt_nxt_s;
   logic                    fill_valid_r, fill_side_r;
   logic [PRICE_W-1:0]      fill_price_r;
   logic signed [POS_W-1:0] position_r;
   logic                    drop_r, conflict_r, reject_r;

   logic   push_s, pop_s, load_s, accept_s, limit_hit_s;
   logic   drop_s, conflict_s;
   logic   fifo_full_s, fifo_empty_s;
   order_t fifo_din_s, fifo_dout_s;

   order_fifo #(
      .DEPTH (DEPTH),
      .T     (order_t)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push_s),
      .pop     (pop_s),
      .din     (fifo_din_s),
      .dout    (fifo_dout_s),
      .full    (fifo_full_s),
      .empty   (fifo_empty_s)
   );

   // Ingress: a single-sided request is queued unless the queue is already full
   always_comb begin
      conflict_s = buy_order & sell_order;
      drop_s     = (buy_order ^ sell_order) & fifo_full_s;
      push_s     = (buy_order ^ sell_order) & ~fifo_full_s;
      fifo_din_s = '{side: side_of(sell_order), price: mkt_price};
   end

   // Position-limit test on the queue head, against the position right now
   always_comb begin
      limit_hit_s = 1'b0;
      if (LIMIT_EN) begin
         if (fifo_dout_s.side == SIDE_BUY) begin
            limit_hit_s = (int'(position_r) >= MAX_POS);
         end else begin
            limit_hit_s = (int'(position_r) <= -MAX_POS);
         end
      end else begin
         limit_hit_s = 1'b0;
      end
   end

   // Fill FSM next state: pop, count down the latency, then hold until accepted
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      pop_s       = 1'b0;
      load_s      = 1'b0;
      accept_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (!fifo_empty_s) begin
               pop_s = 1'b1;
               if (!limit_hit_s) begin
                  load_s      = 1'b1;
                  cnt_nxt_s   = CNT_W'(LATENCY - 1);
                  state_nxt_s = WAIT;
               end else begin
                  state_nxt_s = IDLE;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WAIT: begin
            if (cnt_r == {CNT_W{1'b0}}) begin
               state_nxt_s = PRESENT;
            end else begin
               cnt_nxt_s = cnt_r - CNT_W'(1);
            end
         end
         PRESENT: begin
            if (fill_ready) begin
               accept_s    = 1'b1;
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = PRESENT;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // FSM state, latency counter and the presented fill register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= IDLE;
         cnt_r        <= {CNT_W{1'b0}};
         fill_valid_r <= 1'b0;
         fill_side_r  <= 1'b0;
         fill_price_r <= {PRICE_W{1'b0}};
      end else begin
         state_r      <= state_nxt_s;
         cnt_r        <= cnt_nxt_s;
         fill_valid_r <= (state_nxt_s == PRESENT);
         if (load_s) begin
            fill_side_r  <= fifo_dout_s.side;
            fill_price_r <= fifo_dout_s.price;
         end
      end
   end

   // Net position, moved only when a fill is handed over
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         position_r <= {POS_W{1'b0}};
      end else if (accept_s) begin
         position_r <= pos_step(position_r, side_t'(fill_side_r));
      end
   end

   // One-cycle event flags, reported the cycle after the event
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         drop_r     <= 1'b0;
         conflict_r <= 1'b0;
         reject_r   <= 1'b0;
      end else begin
         drop_r     <= drop_s;
         conflict_r <= conflict_s;
         reject_r   <= pop_s & limit_hit_s;
      end
   end

   assign fill_valid     = fill_valid_r;
   assign fill_side      = fill_side_r;
   assign fill_price     = fill_price_r;
   assign position       = position_r;
   assign order_drop     = drop_r;
   assign order_conflict = conflict_r;
   assign order_reject   = reject_r;
   assign busy           = ~fifo_empty_s | (state_r != IDLE);

endmodule

// File: tb/tb_order_fill_engine.sv
// -----------------------------------------------------------------------------
// tb_order_fill_engine
// Self-checking bench: a per-cycle table for single orders and conflicts,
// hand sequences for queue overflow, long back-pressure, mid-flight reset,
// the position limit (ORDER_POS_LIMIT_EN) and saturation, then random traffic.
// A queue-based reference model is compared every cycle.
// -----------------------------------------------------------------------------
module tb_order_fill_engine;
   import order_pkg::*;

   localparam int PRICE_W = 16;
   localparam int POS_W   = 12;
   localparam int DEPTH   = 8;
   localparam int LATENCY = 4;
`ifdef ORDER_POS_LIMIT_EN
   localparam int MAX_POS = 2;
`else
   localparam int MAX_POS = 100;
`endif
   localparam int PMAX = (2 ** (POS_W - 1)) - 1;
   localparam int PMIN = -(2 ** (POS_W - 1));

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               buy_order = 1'b0, sell_order = 1'b0, fill_ready = 1'b0;
   logic [PRICE_W-1:0] mkt_price = 16'd0;
   logic               fill_valid, fill_side;
   logic [PRICE_W-1:0] fill_price;
   logic [POS_W-1:0]   position;
   logic               order_drop, order_conflict, order_reject, busy;

   always #5 clk = ~clk;

   order_fill_engine #(
      .PRICE_W(PRICE_W), .POS_W(POS_W), .DEPTH(DEPTH), .LATENCY(LATENCY), .MAX_POS(MAX_POS)
   ) dut (
      .clk(clk), .reset_n(reset_n), .buy_order(buy_order), .sell_order(sell_order),
      .mkt_price(mkt_price), .fill_valid(fill_valid), .fill_side(fill_side),
      .fill_price(fill_price), .fill_ready(fill_ready), .position(position),
      .order_drop(order_drop), .order_conflict(order_conflict),
      .order_reject(order_reject), .busy(busy)
   );

   int total = 0;
   int bad   = 0;
   int mdl_bad = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int spos();
      return int'($signed(position));
   endfunction

   // ---------------- reference model: queue + one in-flight slot ----------------
   typedef struct { bit side; int price; } mord_t;
   mord_t mq[$];
   mord_t mh;
   bit m_slot, m_side, m_drop, m_conf, m_rej, m_full, m_slot_before, m_acc;
   int m_rem, m_price, m_pos;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mq.delete();
         m_slot = 1'b0; m_rem = 0; m_side = 1'b0; m_price = 0; m_pos = 0;
         m_drop = 1'b0; m_conf = 1'b0; m_rej = 1'b0;
      end else begin
         m_full        = (mq.size() == DEPTH);
         m_slot_before = m_slot;
         m_acc         = m_slot && (m_rem == 0) && fill_ready;
         m_drop = 1'b0; m_conf = 1'b0; m_rej = 1'b0;
         if (m_acc) begin
            if (m_side == 1'b0) m_pos = (m_pos < PMAX) ? m_pos + 1 : PMAX;
            else                m_pos = (m_pos > PMIN) ? m_pos - 1 : PMIN;
            m_slot = 1'b0;
         end else if (m_slot && m_rem > 0) begin
            m_rem--;
         end
         if (!m_slot_before && mq.size() > 0) begin
            mh = mq.pop_front();
`ifdef ORDER_POS_LIMIT_EN
            if ((mh.side == 1'b0 && m_pos + 1 > MAX_POS) ||
                (mh.side == 1'b1 && m_pos - 1 < -MAX_POS)) begin
               m_rej = 1'b1;
            end else begin
               m_slot = 1'b1; m_rem = LATENCY; m_side = mh.side; m_price = mh.price;
            end
`else
            m_slot = 1'b1; m_rem = LATENCY; m_side = mh.side; m_price = mh.price;
`endif
         end
         if (buy_order && sell_order) begin
            m_conf = 1'b1;
         end else if (buy_order || sell_order) begin
            if (m_full) m_drop = 1'b1;
            else mq.push_back('{side: sell_order, price: int'(mkt_price)});
         end
      end
   end

   // Per-cycle comparison against the model (stops after a burst of failures)
   always @(negedge clk) begin
      if (reset_n && chk_en && mdl_bad < 20) begin
         int b0;
         b0 = bad;
         chk("mdl_valid", int'(fill_valid), int'(m_slot && m_rem == 0));
         if (m_slot && m_rem == 0) begin
            chk("mdl_side", int'(fill_side), int'(m_side));
            chk("mdl_price", int'(fill_price), m_price);
         end
         chk("mdl_pos", spos(), m_pos);
         chk("mdl_drop", int'(order_drop), int'(m_drop));
         chk("mdl_conf", int'(order_conflict), int'(m_conf));
         chk("mdl_rej", int'(order_reject), int'(m_rej));
         chk("mdl_busy", int'(busy), int'(mq.size() > 0 || m_slot));
         mdl_bad += bad - b0;
      end
   end

   // ---------------- helpers ----------------
   task automatic do_reset();
      buy_order = 1'b0; sell_order = 1'b0; fill_ready = 1'b0; mkt_price = 16'd0;
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic wait_valid(input string name, input int budget);
      int c = 0;
      while (!fill_valid && c < budget) begin
         @(negedge clk);
         c++;
      end
      chk(name, int'(fill_valid), 1);
   endtask

   // ---------------- table vectors ----------------
   typedef struct {
      logic buy, sell; int price; logic ready;
      logic ev, es; int ep; int epos; logic edrop, econf, ebusy;
   } vec_t;
   vec_t vec[17];

   function automatic vec_t mk(logic b, logic s, int p, logic r, logic ev, logic es,
                               int ep, int epos, logic ec, logic eb);
      vec_t v;
      v.buy = b; v.sell = s; v.price = p; v.ready = r;
      v.ev = ev; v.es = es; v.ep = ep; v.epos = epos;
      v.edrop = 1'b0; v.econf = ec; v.ebusy = eb;
      return v;
   endfunction

   int drops, nfill, nrej, c;
   int got_price[$];
   int got_side[$];
   bit stable, saw;
   logic       hold_side;
   logic [15:0] hold_price;

   initial begin
      // single buy at 500, then a conflict, then a sell at 77 with a short stall
      vec[0]  = mk(1, 0, 500, 1, 0, 0, 0,   0, 0, 1);
      vec[1]  = mk(0, 0, 0,   1, 0, 0, 0,   0, 0, 1);
      vec[2]  = mk(0, 0, 0,   1, 0, 0, 0,   0, 0, 1);
      vec[3]  = mk(0, 0, 0,   1, 0, 0, 0,   0, 0, 1);
      vec[4]  = mk(0, 0, 0,   1, 0, 0, 0,   0, 0, 1);
      vec[5]  = mk(0, 0, 0,   1, 1, 0, 500, 0, 0, 1);
      vec[6]  = mk(0, 0, 0,   1, 0, 0, 0,   1, 0, 0);
      vec[7]  = mk(1, 1, 999, 1, 0, 0, 0,   1, 1, 0);
      vec[8]  = mk(0, 0, 0,   1, 0, 0, 0,   1, 0, 0);
      vec[9]  = mk(0, 1, 77,  1, 0, 0, 0,   1, 0, 1);
      vec[10] = mk(0, 0, 0,   1, 0, 0, 0,   1, 0, 1);
      vec[11] = mk(0, 0, 0,   1, 0, 0, 0,   1, 0, 1);
      vec[12] = mk(0, 0, 0,   1, 0, 0, 0,   1, 0, 1);
      vec[13] = mk(0, 0, 0,   1, 0, 0, 0,   1, 0, 1);
      vec[14] = mk(0, 0, 0,   0, 1, 1, 77,  1, 0, 1);
      vec[15] = mk(0, 0, 0,   0, 1, 1, 77,  1, 0, 1);
      vec[16] = mk(0, 0, 0,   1, 0, 0, 0,   0, 0, 0);

      // reset state
      #3;
      chk("rst_valid", int'(fill_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_pos", spos(), 0);
      chk("rst_flags", int'({order_drop, order_conflict, order_reject}), 0);
      do_reset();
      chk_en = 1'b1;

      for (int i = 0; i < 17; i++) begin
         buy_order = vec[i].buy; sell_order = vec[i].sell;
         mkt_price = 16'(vec[i].price); fill_ready = vec[i].ready;
         @(negedge clk);
         chk($sformatf("vec%0d_valid", i), int'(fill_valid), int'(vec[i].ev));
         if (vec[i].ev) begin
            chk($sformatf("vec%0d_side", i), int'(fill_side), int'(vec[i].es));
            chk($sformatf("vec%0d_price", i), int'(fill_price), vec[i].ep);
         end
         chk($sformatf("vec%0d_pos", i), spos(), vec[i].epos);
         chk($sformatf("vec%0d_drop", i), int'(order_drop), int'(vec[i].edrop));
         chk($sformatf("vec%0d_conf", i), int'(order_conflict), int'(vec[i].econf));
         chk($sformatf("vec%0d_busy", i), int'(busy), int'(vec[i].ebusy));
      end

`ifndef ORDER_POS_LIMIT_EN
      // overflow: 10 buys with no consumer
      do_reset();
      drops = 0;
      for (int i = 0; i < 10; i++) begin
         buy_order = 1'b1; mkt_price = 16'(100 + i);
         @(negedge clk);
         if (order_drop) drops++;
      end
      buy_order = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (order_drop) drops++;
      end
      chk("ovf_drops", drops, 1);
      chk("ovf_valid", int'(fill_valid), 1);
      chk("ovf_price0", int'(fill_price), 100);
      fill_ready = 1'b1;
      got_price.delete();
      c = 0;
      while (got_price.size() < 10 && c < 200) begin
         if (fill_valid) got_price.push_back(int'(fill_price));
         @(negedge clk);
         c++;
      end
      chk("ovf_nfill", got_price.size(), 9);
      for (int i = 0; i < 9 && i < got_price.size(); i++)
         chk($sformatf("ovf_fill%0d", i), got_price[i], 100 + i);
      chk("ovf_pos", spos(), 9);
      chk("ovf_busy", int'(busy), 0);

      // long back-pressure in PRESENT
      fill_ready = 1'b0; sell_order = 1'b1; mkt_price = 16'd4321;
      @(negedge clk);
      sell_order = 1'b0;
      wait_valid("bp_valid", 20);
      hold_side = fill_side; hold_price = fill_price;
      chk("bp_side", int'(hold_side), 1);
      chk("bp_price", int'(hold_price), 4321);
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!fill_valid || fill_side != hold_side || fill_price != hold_price || spos() != 9)
            stable = 1'b0;
      end
      chk("bp_stable", int'(stable), 1);
      fill_ready = 1'b1;
      @(negedge clk);
      chk("bp_accept_valid", int'(fill_valid), 0);
      chk("bp_accept_pos", spos(), 8);
`endif

      // reset with 3 queued and one counting down
      fill_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         buy_order = 1'b1; mkt_price = 16'(700 + i);
         @(negedge clk);
      end
      buy_order = 1'b0;
      chk("rs_busy_before", int'(busy), 1);
      #2 reset_n = 1'b0;
      #1;
      chk("rs_valid", int'(fill_valid), 0);
      chk("rs_busy", int'(busy), 0);
      chk("rs_pos", spos(), 0);
      chk("rs_side_price", int'({fill_side, fill_price}), 0);
      chk("rs_flags", int'({order_drop, order_conflict, order_reject}), 0);
      @(negedge clk);
      reset_n = 1'b1;
      fill_ready = 1'b1;
      saw = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (fill_valid || busy) saw = 1'b1;
      end
      chk("rs_no_fill", int'(saw), 0);

`ifdef ORDER_POS_LIMIT_EN
      // position limit 2: buy, buy, buy, sell
      do_reset();
      fill_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         buy_order = (i < 3); sell_order = (i == 3); mkt_price = 16'(11 + i);
         @(negedge clk);
      end
      buy_order = 1'b0; sell_order = 1'b0;
      got_side.delete();
      nrej = 0;
      for (int i = 0; i < 60; i++) begin
         if (fill_valid) got_side.push_back(int'(fill_side));
         if (order_reject) nrej++;
         @(negedge clk);
      end
      chk("lim_nfill", got_side.size(), 3);
      if (got_side.size() == 3) begin
         chk("lim_side0", got_side[0], 0);
         chk("lim_side1", got_side[1], 0);
         chk("lim_side2", got_side[2], 1);
      end
      chk("lim_rej", nrej, 1);
      chk("lim_pos", spos(), 1);
`else
      // saturation at both rails under continuous traffic
      do_reset();
      fill_ready = 1'b1; buy_order = 1'b1;
      repeat ((PMAX + 20) * (LATENCY + 2)) @(negedge clk);
      chk("sat_hi", spos(), PMAX);
      buy_order = 1'b0; sell_order = 1'b1;
      repeat ((PMAX - PMIN + 20) * (LATENCY + 2)) @(negedge clk);
      chk("sat_lo", spos(), PMIN);
      sell_order = 1'b0;
`endif

      // random traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = int'($urandom_range(0, 9));
         buy_order  = (r < 3) || (r == 9);
         sell_order = (r >= 3 && r < 6) || (r == 9);
         fill_ready = ((i / 500) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                           : ($urandom_range(0, 3) == 0);
         mkt_price  = 16'($urandom);
         @(negedge clk);
      end
      buy_order = 1'b0; sell_order = 1'b0; fill_ready = 1'b1;
      repeat (80) @(negedge clk);
      chk("rand_drain_busy", int'(busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
